// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the multiplier/divider pair: field widths, bias,
// saturation magnitude and the divider state encoding.
package fp16_pkg;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int BIAS   = 15;
  localparam int Q_W    = MANT_W + 2;
  localparam logic [14:0] SAT_MAG = 15'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Zero is any encoding with a cleared magnitude; the sign bit is ignored.
  function automatic logic is_zero(input logic [15:0] v);
    return (v[14:0] == 15'd0);
  endfunction
endpackage

// File: rtl/mant_div_step.sv
// One restoring-division step: subtract the divisor when it fits, emit the
// quotient bit and shift the partial remainder left.
module mant_div_step
  import fp16_pkg::*;
(
  input  logic [Q_W-1:0]  rem,
  input  logic [MANT_W:0] dvs,
  output logic            qbit,
  output logic [Q_W-1:0]  rem_next
);
  logic [Q_W-1:0] dvs_ext;
  logic [Q_W-1:0] rem_sel;

  always_comb begin
    dvs_ext  = {1'b0, dvs};
    qbit     = (rem >= dvs_ext);
    rem_sel  = qbit ? (rem - dvs_ext) : rem;
    rem_next = rem_sel << 1;
  end
endmodule

// File: rtl/div_half_precision.sv
// Iterative FP16 divider: one quotient bit per clock, then a single
// normalise/pack cycle. Same format as the multiplier (no subnormals/inf/NaN).
module div_half_precision
  import fp16_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Start,
  output logic        o_Ready,
  input  logic [15:0] i_Dividend,
  input  logic [15:0] i_Divisor,
  output logic        o_Valid,
  input  logic        i_Ack,
  output logic [15:0] o_Quotient,
  output logic        o_Exception,
  output state_t      o_Dbg_State
);
  // Handshake: a request is taken on an edge with i_Start && o_Ready (IDLE only);
  // the result is held with o_Valid until an edge with o_Valid && i_Ack, after
  // which the FSM spends at least one cycle in IDLE before the next accept.
  state_t                state_q, state_d;
  logic [Q_W-1:0]        rem_q, quo_q;
  logic [MANT_W:0]       dvs_q;
  logic [3:0]            cnt_q;
  logic [EXP_W-1:0]      exp_a_q, exp_b_q;
  logic                  sign_q;
  logic [15:0]           quot_q;
  logic                  exc_q;

  logic                  accept, dvs_zero, dvd_zero, sign_in;
  logic                  qbit;
  logic [Q_W-1:0]        rem_next;
  logic signed [7:0]     e_calc;
  logic [MANT_W-1:0]     mant_n;
  logic [15:0]           norm_quot;
  logic                  norm_exc;

  assign accept   = i_Start && (state_q == ST_IDLE);
  assign dvs_zero = is_zero(i_Divisor);
  assign dvd_zero = is_zero(i_Dividend);
  assign sign_in  = i_Dividend[15] ^ i_Divisor[15];

  mant_div_step u_step (
    .rem      (rem_q),
    .dvs      (dvs_q),
    .qbit     (qbit),
    .rem_next (rem_next)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (dvs_zero || dvd_zero) ? ST_DONE : ST_DIV;
      ST_DIV:  if (cnt_q == 4'd0) state_d = ST_NORM;
      ST_NORM: state_d = ST_DONE;
      ST_DONE: if (i_Ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Quotient lies in (0.5, 2): a clear MSB means one extra left shift.
  always_comb begin
    e_calc = $signed({3'b000, exp_a_q}) - $signed({3'b000, exp_b_q})
           + $signed(8'(BIAS)) - $signed({7'd0, ~quo_q[Q_W-1]});
    mant_n = quo_q[Q_W-1] ? quo_q[Q_W-2:1] : quo_q[MANT_W-1:0];
    if (e_calc > 8'sd31) begin
      norm_quot = {sign_q, SAT_MAG};
      norm_exc  = 1'b1;
    end else if (e_calc < 8'sd1) begin
      norm_quot = {sign_q, 15'h0000};
      norm_exc  = 1'b1;
    end else begin
      norm_quot = {sign_q, e_calc[EXP_W-1:0], mant_n};
      norm_exc  = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      exp_a_q <= '0;
      exp_b_q <= '0;
      sign_q  <= 1'b0;
      quot_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          sign_q  <= sign_in;
          exp_a_q <= i_Dividend[14:10];
          exp_b_q <= i_Divisor[14:10];
          rem_q   <= {2'b01, i_Dividend[MANT_W-1:0]};
          dvs_q   <= {1'b1, i_Divisor[MANT_W-1:0]};
          quo_q   <= '0;
          cnt_q   <= 4'(Q_W - 1);
          if (dvs_zero) begin
            quot_q <= {sign_in, SAT_MAG};
            exc_q  <= 1'b1;
          end else if (dvd_zero) begin
            quot_q <= 16'h0000;
            exc_q  <= 1'b0;
          end
        end
        ST_DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[Q_W-2:0], qbit};
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        ST_NORM: begin
          quot_q <= norm_quot;
          exc_q  <= norm_exc;
        end
        default: ;
      endcase
    end
  end

  assign o_Ready     = (state_q == ST_IDLE);
  assign o_Valid     = (state_q == ST_DONE);
  assign o_Quotient  = quot_q;
  assign o_Exception = exc_q;
  assign o_Dbg_State = state_q;
endmodule

// File: tb/tb_div_half_precision.sv
// Directed-vector bench for div_half_precision: arithmetic, exceptions,
// latency, handshake holding and asynchronous abort.
module tb_div_half_precision;
  import fp16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] dvd = '0;
  logic [15:0] dvs = '0;
  logic        ready, valid, exc;
  logic [15:0] quot;
  state_t      dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  div_half_precision dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Start     (start),
    .o_Ready     (ready),
    .i_Dividend  (dvd),
    .i_Divisor   (dvs),
    .o_Valid     (valid),
    .i_Ack       (ack),
    .o_Quotient  (quot),
    .o_Exception (exc),
    .o_Dbg_State (dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  // Returns #1 after the accept edge.
  task automatic issue(input string tag, input logic [15:0] a, input logic [15:0] b);
    wait_ready(tag);
    start = 1'b1; dvd = a; dvs = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (!valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic score(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_q"}, 32'(quot), 32'(e[15:0]));
      check({tag, "_exc"}, 32'(exc), 32'(e[16]));
    end
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(valid), 32'd0);
    check({tag, "_ack_ready"}, 32'(ready), 32'd1);
  endtask

  // Latency = edges after the accept edge until o_Valid is seen.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic ee, input int lat);
    exp_q.push_back({ee, eq});
    issue(tag, a, b);
    wait_valid(tag, lat);
    score(tag);
    do_ack(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_quot",  32'(quot),  32'd0);
    check("rst_exc",   32'(exc),   32'd0);
    check("rst_state", 32'(dbg),   32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("one_one",   16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 13);
    run_op("six_two",   16'h4600, 16'h4000, 16'h4200, 1'b0, 13);
    run_op("one_third", 16'h3C00, 16'h4200, 16'h3555, 1'b0, 13);
    run_op("neg_six",   16'hC600, 16'h4000, 16'hC200, 1'b0, 13);
    run_op("div_zero",  16'hC000, 16'h0000, 16'hFFFF, 1'b1, 0);
    run_op("zero_dvd",  16'h0000, 16'h4000, 16'h0000, 1'b0, 0);
    run_op("zero_zero", 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 0);
    run_op("overflow",  16'h7800, 16'h0400, 16'h7FFF, 1'b1, 13);
    run_op("underflow", 16'h8400, 16'h7800, 16'h8000, 1'b1, 13);
    run_op("exp_max",   16'h7C00, 16'h3C00, 16'h7C00, 1'b0, 13);
    run_op("exp_min",   16'h0400, 16'h3C00, 16'h0400, 1'b0, 13);
    run_op("exp_zero",  16'h0400, 16'h3E00, 16'h0000, 1'b1, 13);

    // Busy-time start pulses and operand changes must not disturb 6/2.
    exp_q.push_back({1'b0, 16'h4200});
    issue("busy", 16'h4600, 16'h4000);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; dvd = 16'h3C00; dvs = 16'h4200;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_valid("busy", 8);
    score("busy");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_quot",  32'(quot),  32'h4200);
    end

    // Start held through the ack edge: accept only from the following IDLE cycle.
    start = 1'b1; dvd = 16'h3C00; dvs = 16'h3C00; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("ack_no_accept_state", 32'(dbg),   32'(ST_IDLE));
    check("ack_no_accept_valid", 32'(valid), 32'd0);
    exp_q.push_back({1'b0, 16'h3C00});
    @(posedge clk); #1;
    start = 1'b0;
    check("late_accept_state", 32'(dbg), 32'(ST_DIV));
    wait_valid("late_accept", 13);
    score("late_accept");
    do_ack("late_accept");

    // Asynchronous abort in the middle of the division (counter at 5).
    issue("abort", 16'h4600, 16'h4000);
    repeat (6) begin @(posedge clk); #1; end
    check("abort_pre_state", 32'(dbg), 32'(ST_DIV));
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_quot",  32'(quot),  32'd0);
    check("abort_exc",   32'(exc),   32'd0);
    check("abort_state", 32'(dbg),   32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 13);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
